dec_stage: RTL and testbench
============================

Name: dec_stage

Overview:
- Registered, parametrised RV32I/RV64I decode stage; successor to the combinational decoder.
- Buffers fetched instructions in a DEPTH-entry FIFO and decodes the FIFO head into a registered output slot.
- Adds valid/ready handshakes on both sides, flush, illegal-instruction detection and XLEN generalisation.
- Sits between fetch and execute in the soc pipeline.

Parameters:
- XLEN, 32, data/immediate width; legal values 32 or 64.
- DEPTH, 2, FIFO entries; power of two, >= 2.

Ports:
- clock  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high.
- flush  in  1  synchronous; drops FIFO contents and output slot.
- in_valid  in  1  fetch offers instruction.
- in_ready  out  1  stage can accept.
- in_inst  in  32  raw instruction.
- in_pc  in  XLEN  instruction address.
- out_valid  out  1  decoded slot valid.
- out_ready  in  1  execute consumes.
- out_pc  out  XLEN  pc of decoded instruction.
- rd, rs1, rs2  out  5 each  register ids.
- imm  out  XLEN  sign-extended immediate (I/S/B/U/J), 0 for R-type.
- alu_op  out  4, com_op  out  3, is_mem_sign  out  1, inst_type  out  5  encodings per the shared soc definitions header.
- illegal  out  1  instruction not legal for XLEN.

Behaviour:
- Reset (async, active-high): FIFO empty; out_valid=0; all decoded outputs, out_pc and illegal = 0.
- in_ready = (count < DEPTH). No pass-through when full: a simultaneous pop does not raise in_ready in that cycle.
- Push on in_valid && in_ready. Pointers wrap modulo DEPTH; count width is clog2(DEPTH)+1.
- Output slot loads from the FIFO head when the FIFO is non-empty and (!out_valid || out_ready). This pops the FIFO in the same edge.
- If the slot empties with no FIFO entry available, out_valid drops to 0.
- Latency: an instruction pushed at edge k, into an empty stage with out_ready=1, shows out_valid=1 after edge k+1. Throughput is one instruction per cycle.
- Outputs are held stable while out_valid && !out_ready.
- Decode fields:
  - opcode=inst[6:0], rd=[11:7], funct3=[14:12], rs1=[19:15], rs2=[24:20].
  - Immediates are sign-extended from inst[31] to XLEN.
- alu_op:
  - OP-IMM: {inst[30] & funct3==SR, funct3}.
  - OP: {inst[30], funct3}.
  - SYSTEM: {2'b01, funct3[1:0]}.
  - Otherwise ADD.
- com_op = funct3 for BRANCH, else EQ.
- inst_type:
  - LOAD: {3'b011, funct3[1:0]}.
  - STORE: {3'b010, funct3[1:0]}.
  - SYSTEM: {2'b10, funct3}.
- is_mem_sign = !funct3[2].
- illegal=1, and inst_type forced to 0, when any of:
  - opcode is not one of LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP-IMM, OP, SYSTEM.
  - BRANCH funct3 is 2 or 3.
  - JALR funct3 != 0.
  - LOAD funct3 is 7, or 3/6 with XLEN=32.
  - STORE funct3 >= 4, or 3 with XLEN=32.
  - OP funct7 is not 0x00/0x20, or funct7=0x20 with funct3 not ADD/SR.
  - OP-IMM shift with inst[31:26] not 0/0x10, or inst[25]=1 with XLEN=32.
- Illegal instructions still flow through the handshake; execute traps on them.
- flush: at the next edge, count=0 and out_valid=0. Flush overrides a same-cycle push and pop; the pushed instruction is discarded.
- Reset asserted mid-operation clears everything immediately, regardless of the clock.

Optional Feature:
- Macro DEC_PERF_CNT_EN.
- Defined:
  - Adds outputs perf_dec_cnt (32) and perf_stall_cnt (32).
  - perf_dec_cnt increments on each out_valid && out_ready.
  - perf_stall_cnt increments each cycle with out_valid && !out_ready.
  - Both wrap at 2^32, reset to 0, and are unaffected by flush.
- Undefined: the ports and counters do not exist. Decode behaviour is identical.

Test Plan:
- Reset, push addi x1,x0,-5 (0xFFB00093), out_ready=1 -> one cycle later: out_valid=1, rd=1, rs1=0, imm=0xFFFFFFFB, alu_op=0, illegal=0.
- DEPTH=2, out_ready=0, push 4 instructions -> 3 accepted (2 in FIFO + 1 in slot), in_ready=0. Release out_ready -> all 3 emerge in order, one per cycle.
- Push 0x0000007F (bad opcode) -> illegal=1, inst_type=0. Push beq (0x00208463) -> com_op=0, imm=8, illegal=0.
- XLEN=32: ld x1,0(x2) (0x00013083) gives illegal=1. XLEN=64: the same instruction gives illegal=0 and imm is 64-bit zero.
- Full FIFO with out_valid=1 plus same-cycle push and flush -> next cycle out_valid=0, in_ready=1, and the pushed instruction never appears.
- DEC_PERF_CNT_EN: 3 cycles stalled, then 2 accepted -> perf_stall_cnt=3, perf_dec_cnt=2.

Source files
------------

// File: rtl/dec_stage.sv
// dec_stage: registered RV32I/RV64I decode stage with an input FIFO and a decoded output slot
//
// Optional feature: define DEC_PERF_CNT_EN to add the perf_dec_cnt / perf_stall_cnt counters.
//
// Ports:
//   clock, reset         rising-edge clock, asynchronous active-high reset
//   flush                synchronous drop of FIFO contents and output slot
//   in_valid/in_ready    fetch handshake; in_inst, in_pc carry the instruction
//   out_valid/out_ready  execute handshake on the decoded slot
//   out_pc               pc of the decoded instruction
//   rd, rs1, rs2         register ids
//   imm                  sign-extended immediate (0 for R-type)
//   alu_op, com_op       ALU and branch-compare operation codes
//   is_mem_sign          signed load/store flag (!funct3[2])
//   inst_type            instruction class (0 when illegal)
//   illegal              instruction is not legal for XLEN
//   perf_dec_cnt         [DEC_PERF_CNT_EN] count of consumed decodes
//   perf_stall_cnt       [DEC_PERF_CNT_EN] count of cycles stalled by execute
module dec_stage #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 2
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_inst,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [4:0]      rd,
    output logic [4:0]      rs1,
    output logic [4:0]      rs2,
    output logic [XLEN-1:0] imm,
    output logic [3:0]      alu_op,
    output logic [2:0]      com_op,
    output logic            is_mem_sign,
    output logic [4:0]      inst_type,
`ifdef DEC_PERF_CNT_EN
    output logic [31:0]     perf_dec_cnt,
    output logic [31:0]     perf_stall_cnt,
`endif
    output logic            illegal
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    localparam logic [3:0] ALU_ADD = 4'd0;
    localparam logic [2:0] CMP_EQ  = 3'd0;
    localparam logic [2:0] F3_SR   = 3'd5;

    // Classes outside LOAD (011xx), STORE (010xx) and SYSTEM (10xxx); 0 marks illegal.
    localparam logic [4:0] T_OP    = 5'd1;
    localparam logic [4:0] T_OPIMM = 5'd2;
    localparam logic [4:0] T_LUI   = 5'd3;
    localparam logic [4:0] T_AUIPC = 5'd4;
    localparam logic [4:0] T_JAL   = 5'd5;
    localparam logic [4:0] T_JALR  = 5'd6;
    localparam logic [4:0] T_BR    = 5'd7;

    logic [31:0]     r_inst_q [DEPTH];
    logic [XLEN-1:0] r_pc_q   [DEPTH];
    logic [AW-1:0]   r_wptr;
    logic [AW-1:0]   r_rptr;
    logic [AW:0]     r_cnt;

    logic            w_push;
    logic            w_pop;
    logic [31:0]     w_inst;
    logic [6:0]      w_opc;
    logic [2:0]      w_f3;
    logic [6:0]      w_f7;
    logic [XLEN-1:0] w_imm_i;
    logic [XLEN-1:0] w_imm_s;
    logic [XLEN-1:0] w_imm_b;
    logic [XLEN-1:0] w_imm_u;
    logic [XLEN-1:0] w_imm_j;
    logic [XLEN-1:0] w_imm;
    logic [3:0]      w_alu;
    logic [4:0]      w_type;
    logic            w_bad;

    // in_ready looks only at the registered count: no pass-through when full.
    assign in_ready = r_cnt < FULL;
    assign w_push   = in_valid && in_ready;
    assign w_pop    = (r_cnt != '0) && (!out_valid || out_ready);

    assign w_inst = r_inst_q[r_rptr];
    assign w_opc  = w_inst[6:0];
    assign w_f3   = w_inst[14:12];
    assign w_f7   = w_inst[31:25];

    assign w_imm_i = XLEN'($signed(w_inst[31:20]));
    assign w_imm_s = XLEN'($signed({w_inst[31:25], w_inst[11:7]}));
    assign w_imm_b = XLEN'($signed({w_inst[31], w_inst[7], w_inst[30:25], w_inst[11:8], 1'b0}));
    assign w_imm_u = XLEN'($signed({w_inst[31:12], 12'b0}));
    assign w_imm_j = XLEN'($signed({w_inst[31], w_inst[19:12], w_inst[20], w_inst[30:21], 1'b0}));

    always_comb begin
        w_imm  = '0;
        w_alu  = ALU_ADD;
        w_type = '0;
        w_bad  = 1'b0;
        case (w_opc)
            OPC_LUI: begin
                w_imm  = w_imm_u;
                w_type = T_LUI;
            end
            OPC_AUIPC: begin
                w_imm  = w_imm_u;
                w_type = T_AUIPC;
            end
            OPC_JAL: begin
                w_imm  = w_imm_j;
                w_type = T_JAL;
            end
            OPC_JALR: begin
                w_imm  = w_imm_i;
                w_type = T_JALR;
                w_bad  = w_f3 != 3'd0;
            end
            OPC_BRANCH: begin
                w_imm  = w_imm_b;
                w_type = T_BR;
                w_bad  = w_f3[2:1] == 2'b01;
            end
            OPC_LOAD: begin
                w_imm  = w_imm_i;
                w_type = {3'b011, w_f3[1:0]};
                w_bad  = (w_f3 == 3'd7) || (XLEN == 32 && (w_f3 == 3'd3 || w_f3 == 3'd6));
            end
            OPC_STORE: begin
                w_imm  = w_imm_s;
                w_type = {3'b010, w_f3[1:0]};
                w_bad  = w_f3[2] || (XLEN == 32 && w_f3 == 3'd3);
            end
            OPC_OPIMM: begin
                w_imm  = w_imm_i;
                w_alu  = {w_inst[30] & (w_f3 == F3_SR), w_f3};
                w_type = T_OPIMM;
                // Shifts (funct3 1/5): upper bits must be 0 or 0x10; shamt[5] only exists on RV64.
                w_bad  = (w_f3[1:0] == 2'b01) &&
                         ((w_inst[31:26] != 6'h00 && w_inst[31:26] != 6'h10) || (XLEN == 32 && w_inst[25]));
            end
            OPC_OP: begin
                w_alu  = {w_inst[30], w_f3};
                w_type = T_OP;
                w_bad  = (w_f7 != 7'h00 && w_f7 != 7'h20) ||
                         (w_f7 == 7'h20 && w_f3 != 3'd0 && w_f3 != F3_SR);
            end
            OPC_SYSTEM: begin
                w_imm  = w_imm_i;
                w_alu  = {2'b01, w_f3[1:0]};
                w_type = {2'b10, w_f3};
            end
            default: w_bad = 1'b1;
        endcase
    end

    // FIFO storage carries no reset; validity is tracked by the count.
    always_ff @(posedge clock) begin
        if (w_push) begin
            r_inst_q[r_wptr] <= in_inst;
            r_pc_q[r_wptr]   <= in_pc;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_cnt  <= '0;
        end else if (flush) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_cnt  <= '0;
        end else begin
            r_wptr <= w_push ? r_wptr + 1'b1 : r_wptr;
            r_rptr <= w_pop ? r_rptr + 1'b1 : r_rptr;
            r_cnt  <= (w_push && !w_pop) ? r_cnt + 1'b1 :
                      (!w_push && w_pop) ? r_cnt - 1'b1 : r_cnt;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            out_valid   <= 1'b0;
            out_pc      <= '0;
            rd          <= '0;
            rs1         <= '0;
            rs2         <= '0;
            imm         <= '0;
            alu_op      <= '0;
            com_op      <= '0;
            is_mem_sign <= 1'b0;
            inst_type   <= '0;
            illegal     <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (w_pop) begin
            out_valid   <= 1'b1;
            out_pc      <= r_pc_q[r_rptr];
            rd          <= w_inst[11:7];
            rs1         <= w_inst[19:15];
            rs2         <= w_inst[24:20];
            imm         <= w_imm;
            alu_op      <= w_alu;
            com_op      <= (w_opc == OPC_BRANCH) ? w_f3 : CMP_EQ;
            is_mem_sign <= !w_f3[2];
            inst_type   <= w_bad ? 5'd0 : w_type;
            illegal     <= w_bad;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

`ifdef DEC_PERF_CNT_EN
    // Counters survive flush; only reset clears them.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            perf_dec_cnt   <= '0;
            perf_stall_cnt <= '0;
        end else begin
            perf_dec_cnt   <= perf_dec_cnt + {31'd0, out_valid && out_ready};
            perf_stall_cnt <= perf_stall_cnt + {31'd0, out_valid && !out_ready};
        end
    end
`endif

endmodule

// File: tb/tb_dec_stage.sv
// tb_dec_stage: directed self-checking bench for dec_stage (XLEN=32 and XLEN=64 instances)
module tb_dec_stage;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [31:0] in_inst = '0;
    logic [63:0] in_pc = '0;

    logic        in_ready, out_valid, is_mem_sign, illegal;
    logic [31:0] out_pc, imm;
    logic [4:0]  rd, rs1, rs2, inst_type;
    logic [3:0]  alu_op;
    logic [2:0]  com_op;

    logic        x_in_ready, x_out_valid, x_is_mem_sign, x_illegal;
    logic [63:0] x_out_pc, x_imm;
    logic [4:0]  x_rd, x_rs1, x_rs2, x_inst_type;
    logic [3:0]  x_alu_op;
    logic [2:0]  x_com_op;

`ifdef DEC_PERF_CNT_EN
    logic [31:0] perf_dec_cnt, perf_stall_cnt, x_perf_dec_cnt, x_perf_stall_cnt;
    logic [31:0] d0, s0;
`endif

    int n_tot = 0;
    int n_bad = 0;

    dec_stage #(.XLEN(32), .DEPTH(2)) dut (
        .clock(clock), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst), .in_pc(in_pc[31:0]),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
        .rd(rd), .rs1(rs1), .rs2(rs2), .imm(imm), .alu_op(alu_op), .com_op(com_op),
        .is_mem_sign(is_mem_sign), .inst_type(inst_type),
`ifdef DEC_PERF_CNT_EN
        .perf_dec_cnt(perf_dec_cnt), .perf_stall_cnt(perf_stall_cnt),
`endif
        .illegal(illegal)
    );

    dec_stage #(.XLEN(64), .DEPTH(2)) d64 (
        .clock(clock), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(x_in_ready), .in_inst(in_inst), .in_pc(in_pc),
        .out_valid(x_out_valid), .out_ready(out_ready), .out_pc(x_out_pc),
        .rd(x_rd), .rs1(x_rs1), .rs2(x_rs2), .imm(x_imm), .alu_op(x_alu_op), .com_op(x_com_op),
        .is_mem_sign(x_is_mem_sign), .inst_type(x_inst_type),
`ifdef DEC_PERF_CNT_EN
        .perf_dec_cnt(x_perf_dec_cnt), .perf_stall_cnt(x_perf_stall_cnt),
`endif
        .illegal(x_illegal)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tot++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic send(input logic [31:0] inst, input logic [63:0] pc);
        in_inst  = inst;
        in_pc    = pc;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
    endtask

    task automatic vec(input string tag, input logic [31:0] inst, input logic [31:0] e_imm,
                       input logic [3:0] e_alu, input logic [4:0] e_type, input logic e_ill,
                       input logic e_ill64);
        send(inst, 64'h400);
        chk({tag, ".valid"}, out_valid, 1);
        chk({tag, ".imm"}, imm, e_imm);
        chk({tag, ".alu"}, alu_op, e_alu);
        chk({tag, ".type"}, inst_type, e_type);
        chk({tag, ".ill"}, illegal, e_ill);
        chk({tag, ".ill64"}, x_illegal, e_ill64);
    endtask

    initial begin
        #12 reset = 1'b0;
        chk("rst.valid", out_valid, 0);
        chk("rst.ready", in_ready, 1);
        chk("rst.imm", imm, 0);
        chk("rst.pc", out_pc, 0);
        chk("rst.ill", illegal, 0);
`ifdef DEC_PERF_CNT_EN
        chk("rst.pdec", perf_dec_cnt, 0);
        chk("rst.pstall", perf_stall_cnt, 0);
`endif

        // addi x1,x0,-5: visible one edge after the push
        out_ready = 1'b1;
        in_inst   = 32'hFFB00093;
        in_pc     = 64'h100;
        in_valid  = 1'b1;
        step();
        in_valid = 1'b0;
        chk("addi.early", out_valid, 0);
        step();
        chk("addi.valid", out_valid, 1);
        chk("addi.rd", rd, 1);
        chk("addi.rs1", rs1, 0);
        chk("addi.imm", imm, 32'hFFFFFFFB);
        chk("addi.alu", alu_op, 0);
        chk("addi.ill", illegal, 0);
        chk("addi.pc", out_pc, 32'h100);
        chk("addi.type", inst_type, 2);
        step();
        chk("addi.drop", out_valid, 0);

        // backpressure: 3 of 4 accepted, then drained in order
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_inst = 32'h00000113; in_pc = 64'h200; step();
        in_inst = 32'h00000193; in_pc = 64'h204; step();
        in_inst = 32'h00000213; in_pc = 64'h208; step();
        chk("bp.full", in_ready, 0);
        in_inst = 32'h00000293; in_pc = 64'h20C; step();
        chk("bp.full2", in_ready, 0);
        chk("bp.hold.pc", out_pc, 32'h200);
        chk("bp.hold.rd", rd, 2);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        chk("bp.b.pc", out_pc, 32'h204);
        chk("bp.b.rd", rd, 3);
        chk("bp.b.ready", in_ready, 1);
        step();
        chk("bp.c.pc", out_pc, 32'h208);
        chk("bp.c.valid", out_valid, 1);
        step();
        chk("bp.empty", out_valid, 0);

        // bad opcode followed back-to-back by beq
        in_valid = 1'b1;
        in_inst = 32'h0000007F; step();
        in_inst = 32'h00208463; step();
        in_valid = 1'b0;
        chk("bad.ill", illegal, 1);
        chk("bad.type", inst_type, 0);
        step();
        chk("beq.valid", out_valid, 1);
        chk("beq.ill", illegal, 0);
        chk("beq.com", com_op, 0);
        chk("beq.imm", imm, 8);
        chk("beq.rs1", rs1, 1);
        chk("beq.rs2", rs2, 2);
        chk("beq.type", inst_type, 7);
        step();

        //  tag       inst           imm           alu   type  ill  ill64
        vec("sub",   32'h403100B3, 32'h0,        4'h8, 5'd1,  0, 0);
        vec("sll20", 32'h403110B3, 32'h0,        4'h9, 5'd0,  1, 1);
        vec("lui",   32'h123450B7, 32'h12345000, 4'h0, 5'd3,  0, 0);
        vec("srai",  32'h40315093, 32'h403,      4'hD, 5'd2,  0, 0);
        vec("slli32",32'h02011093, 32'h20,       4'h1, 5'd0,  1, 0);
        vec("sw",    32'h0020A223, 32'h4,        4'h0, 5'd10, 0, 0);
        vec("jal",   32'hFFDFF0EF, 32'hFFFFFFFC, 4'h0, 5'd5,  0, 0);
        vec("csrrw", 32'h30011073, 32'h300,      4'h5, 5'd17, 0, 0);
        vec("jalr1", 32'h000010E7, 32'h0,        4'h0, 5'd0,  1, 1);
        vec("br2",   32'h00002063, 32'h0,        4'h0, 5'd0,  1, 1);
        vec("lw",    32'h00012083, 32'h0,        4'h0, 5'd14, 0, 0);
        vec("ld",    32'h00013083, 32'h0,        4'h0, 5'd0,  1, 0);
        chk("ld.imm64", x_imm, 64'h0);
        chk("ld.type64", x_inst_type, 15);
        chk("ld.sign64", x_is_mem_sign, 1);
        step();

        // flush with full FIFO, a valid slot and an offered push
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_inst = 32'h00000113; step();
        in_inst = 32'h00000193; step();
        in_inst = 32'h00000213; step();
        in_inst = 32'h00000293;
        flush   = 1'b1;
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("fl1.valid", out_valid, 0);
        chk("fl1.ready", in_ready, 1);
        out_ready = 1'b1;
        step();
        step();
        chk("fl1.gone", out_valid, 0);

        // flush with an accepted push and a pop in the same cycle
        in_valid = 1'b1;
        in_inst = 32'h00000113; step();
        in_inst = 32'h00000193; step();
        in_inst = 32'h00000213;
        flush   = 1'b1;
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("fl2.valid", out_valid, 0);
        chk("fl2.ready", in_ready, 1);
        step();
        chk("fl2.gone1", out_valid, 0);
        step();
        chk("fl2.gone2", out_valid, 0);

`ifdef DEC_PERF_CNT_EN
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_inst = 32'h00000113; step();
        in_inst = 32'h00000193; step();
        in_valid = 1'b0;
        d0 = perf_dec_cnt;
        s0 = perf_stall_cnt;
        step(); step(); step();
        out_ready = 1'b1;
        step(); step();
        chk("perf.stall", perf_stall_cnt - s0, 3);
        chk("perf.dec", perf_dec_cnt - d0, 2);
`endif

        // asynchronous reset between edges
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_inst   = 32'hFFB00093;
        in_pc     = 64'h300;
        step();
        in_valid = 1'b0;
        step();
        chk("ar.pre", out_valid, 1);
        #2 reset = 1'b1;
        #1;
        chk("ar.valid", out_valid, 0);
        chk("ar.pc", out_pc, 0);
        chk("ar.imm", imm, 0);
        chk("ar.valid64", x_out_valid, 0);
        reset = 1'b0;
        step();
        chk("ar.ready", in_ready, 1);

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end
endmodule
